u409_cycle_decode: RTL and testbench
====================================

// Module: u409_cycle_decode
// PURPOSE
//  Upstream address decoder and cycle terminator for U409 autoconfig and devices. Samples each CPU
//  transfer start (TSn), decodes A[31:16] against configured base addresses. Produces
//  AUTOCONFIG_SPACE for the autoconfig block and one-hot device selects. Merges device ack pulses
//  (incl. AC_TACK) into open-drain TAn; watchdog asserts TEAn when a claimed cycle is never acked.
// PARAMETERS
//  TIMEOUT  255    claimed-cycle cycles (CLK40) without ack before bus error; legal 2..2^CNT_W-1
//  CNT_W    8      watchdog counter width
//  AC_PAGE  16'h00E8  A[31:16] of the Zorro II autoconfig page
// PORTS
//  CLK40            in   1   system clock, all logic on rising edge
//  RESETn           in   1   reset, synchronous, active-low
//  A                in   16  CPU address A[31:16]
//  TSn              in   1   CPU transfer start, active-low, one clock
//  CONFIGURED       in   1   all autoconfig devices configured; enables base decodes
//  BRIDGE_BASE      in   8   bridge 64K base, compared to A[23:16]
//  LIDE_BASE        in   7   LIDE 128K base [7:1], compared to A[23:17]
//  PRO_BASE         in   4   Prometheus 256MB base, compared to A[31:28]
//  AC_TACK          in   1   autoconfig ack pulse, active-high
//  BRIDGE_ACK       in   1   bridge ack pulse, active-high
//  LIDE_ACK         in   1   LIDE ack pulse, active-high
//  PRO_ACK          in   1   Prometheus ack pulse, active-high
//  AUTOCONFIG_SPACE out  1   combinational: !CONFIGURED && A==AC_PAGE
//  BRIDGE_SEL       out  1   registered select, held for claimed cycle
//  LIDE_SEL         out  1   registered select
//  PRO_SEL          out  1   registered select
//  TAn              out  1   transfer ack, active-low (valid when TERM_OE=1)
//  TEAn             out  1   transfer error, active-low (valid when TERM_OE=1)
//  TERM_OE          out  1   output enable for TAn/TEAn pad drivers
// BEHAVIOUR
//  Reset: all SELs 0, TAn=1, TEAn=1, TERM_OE=0, counter 0, state IDLE. Reset mid-cycle aborts
//   silently; no TA/TEA is issued for the aborted cycle.
//  Hit terms (evaluated in IDLE on the edge TSn=0):
//   AC   = AUTOCONFIG_SPACE
//   PRO  = CONFIGURED && A[31:28]==PRO_BASE
//   BRG  = CONFIGURED && A[31:24]==0 && A[23:16]==BRIDGE_BASE
//   LIDE = CONFIGURED && A[31:24]==0 && A[23:17]==LIDE_BASE
//   Priority AC>PRO>BRG>LIDE; exactly one claim. Overlapping bases are a software error, not flagged.
//  FSM states:
//   IDLE: TSn=0 with any hit -> ACTIVE; latch claim; raise matching SEL next edge; counter=0.
//         No hit -> stay IDLE, drive nothing. AC claim raises no SEL (autoconfig block self-starts).
//   ACTIVE: counter+1 per clock; only the claimed device's ack is honoured, others ignored.
//         Ack -> TERM_TA. Else counter==TIMEOUT-1 -> TERM_TEA. Ack and timeout same edge: ack wins.
//   TERM_TA/TERM_TEA: one clock, TERM_OE=1, TAn (or TEAn) =0, other =1; SEL cleared -> RECOVER.
//   RECOVER: one clock, TERM_OE=1, TAn=TEAn=1 (active negate) -> IDLE with TERM_OE=0.
//  Latency: ack sampled at edge N -> TAn low during cycle N+1; min claimed cycle TSn->TAn = 3 clocks.
//  TSn low while not IDLE is ignored (no nesting). Acks outside ACTIVE are ignored.
//  Counter saturates; never wraps during a cycle. A/bases read only at TSn edge; later changes ignored.
//  CONFIGURED rising mid-cycle does not alter the current claim.
// TESTING
//  1 Reset, CONFIGURED=0, A=16'h00E8, TSn pulse -> AUTOCONFIG_SPACE=1, no SEL;
//    AC_TACK 2 clk later -> TAn=0 one clk, TERM_OE=1 two clk.
//  2 CONFIGURED=1, BRIDGE_BASE=8'hE9, A=16'h00E9, TSn -> BRIDGE_SEL=1; BRIDGE_ACK after 4 clk -> TAn low,
//    SEL drops same edge.
//  3 PRO_BASE=4'h4, A=16'h4123, no ack -> TEAn=0 exactly TIMEOUT clocks after claim; TAn stays 1.
//  4 Claimed LIDE (LIDE_BASE=7'h75, A=16'h00EB), PRO_ACK pulsed -> ignored; LIDE_ACK + timeout same edge
//    -> TAn, not TEAn.
//  5 A=16'h0010 (no hit), TSn -> TERM_OE stays 0, no SEL; second TSn during ACTIVE cycle -> ignored.
//  6 RESETn low during ACTIVE -> next clk all SEL 0, TERM_OE 0; no TA/TEA ever issued for that cycle.

Source files
------------

// File: rtl/u409_cycle_decode.sv
// Address decoder and cycle terminator for U409 autoconfig and devices: claims a CPU cycle on TSn,
// drives a one-hot select, then terminates with TAn on the claimed ack or TEAn on watchdog expiry.
module u409_cycle_decode #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 8,
   parameter logic [15:0] AC_PAGE = 16'h00E8
) (
   input  logic        CLK40,
   input  logic        RESETn,
   input  logic [15:0] A,
   input  logic        TSn,
   input  logic        CONFIGURED,
   input  logic [7:0]  BRIDGE_BASE,
   input  logic [6:0]  LIDE_BASE,
   input  logic [3:0]  PRO_BASE,
   input  logic        AC_TACK,
   input  logic        BRIDGE_ACK,
   input  logic        LIDE_ACK,
   input  logic        PRO_ACK,
   output logic        AUTOCONFIG_SPACE,
   output logic        BRIDGE_SEL,
   output logic        LIDE_SEL,
   output logic        PRO_SEL,
   output logic        TAn,
   output logic        TEAn,
   output logic        TERM_OE
);

   typedef enum logic [2:0] {StIdle, StActive, StTermTa, StTermTea, StRecover} state_e;

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [3:0]       claim_q, claim_d;  // one-hot {lide, brg, pro, ac}
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hit_ac, hit_pro, hit_brg, hit_lide;
   logic             claim_ack;

   assign AUTOCONFIG_SPACE = !CONFIGURED && (A == AC_PAGE);

   assign hit_ac   = AUTOCONFIG_SPACE;
   assign hit_pro  = CONFIGURED && (A[15:12] == PRO_BASE);
   assign hit_brg  = CONFIGURED && (A[15:8] == 8'h00) && (A[7:0] == BRIDGE_BASE);
   assign hit_lide = CONFIGURED && (A[15:8] == 8'h00) && (A[7:1] == LIDE_BASE);

   // Only the ack of the device that owns the cycle can terminate it.
   assign claim_ack = |(claim_q & {LIDE_ACK, BRIDGE_ACK, PRO_ACK, AC_TACK});

   always_comb begin
      state_d = state_q;
      claim_d = claim_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (!TSn && (hit_ac || hit_pro || hit_brg || hit_lide)) begin
               state_d = StActive;
               cnt_d   = '0;
               if (hit_ac)       claim_d = 4'b0001;
               else if (hit_pro) claim_d = 4'b0010;
               else if (hit_brg) claim_d = 4'b0100;
               else              claim_d = 4'b1000;
            end
         end
         StActive: begin
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
            if (claim_ack) begin
               state_d = StTermTa;
               claim_d = '0;
            end else if (cnt_q == CntLast) begin
               state_d = StTermTea;
               claim_d = '0;
            end
         end
         StTermTa, StTermTea: state_d = StRecover;
         StRecover:           state_d = StIdle;
         default:             state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK40) begin
      if (!RESETn) begin
         state_q <= StIdle;
         claim_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         claim_q <= claim_d;
         cnt_q   <= cnt_d;
      end
   end

   // An autoconfig claim (claim_q[0]) has no select; that block starts on its own.
   assign PRO_SEL    = claim_q[1];
   assign BRIDGE_SEL = claim_q[2];
   assign LIDE_SEL   = claim_q[3];

   assign TAn     = (state_q != StTermTa);
   assign TEAn    = (state_q != StTermTea);
   assign TERM_OE = (state_q == StTermTa) || (state_q == StTermTea) || (state_q == StRecover);

endmodule

// File: tb/tb_u409_cycle_decode.sv
// Directed bench for u409_cycle_decode: claim, ack, watchdog, priority and reset-abort scenarios.
module tb_u409_cycle_decode;

   localparam int unsigned TIMEOUT = 255;

   logic        CLK40 = 1'b0;
   logic        RESETn;
   logic [15:0] A;
   logic        TSn;
   logic        CONFIGURED;
   logic [7:0]  BRIDGE_BASE;
   logic [6:0]  LIDE_BASE;
   logic [3:0]  PRO_BASE;
   logic        AC_TACK, BRIDGE_ACK, LIDE_ACK, PRO_ACK;
   logic        AUTOCONFIG_SPACE, BRIDGE_SEL, LIDE_SEL, PRO_SEL, TAn, TEAn, TERM_OE;

   int n_pass  = 0;
   int n_total = 0;

   u409_cycle_decode dut (
      .CLK40            (CLK40),
      .RESETn           (RESETn),
      .A                (A),
      .TSn              (TSn),
      .CONFIGURED       (CONFIGURED),
      .BRIDGE_BASE      (BRIDGE_BASE),
      .LIDE_BASE        (LIDE_BASE),
      .PRO_BASE         (PRO_BASE),
      .AC_TACK          (AC_TACK),
      .BRIDGE_ACK       (BRIDGE_ACK),
      .LIDE_ACK         (LIDE_ACK),
      .PRO_ACK          (PRO_ACK),
      .AUTOCONFIG_SPACE (AUTOCONFIG_SPACE),
      .BRIDGE_SEL       (BRIDGE_SEL),
      .LIDE_SEL         (LIDE_SEL),
      .PRO_SEL          (PRO_SEL),
      .TAn              (TAn),
      .TEAn             (TEAn),
      .TERM_OE          (TERM_OE)
   );

   always #10 CLK40 = ~CLK40;

   // Outputs sampled and inputs changed 1ns after the rising edge.
   task automatic tick();
      @(posedge CLK40);
      #1;
   endtask

   // Packed {BRIDGE_SEL, LIDE_SEL, PRO_SEL, TERM_OE, TAn, TEAn}
   function automatic logic [5:0] outs();
      return {BRIDGE_SEL, LIDE_SEL, PRO_SEL, TERM_OE, TAn, TEAn};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      logic early_tea;
      logic any_term;
      RESETn = 1'b0; TSn = 1'b1; A = 16'h0000; CONFIGURED = 1'b0;
      BRIDGE_BASE = 8'h00; LIDE_BASE = 7'h00; PRO_BASE = 4'hF;
      AC_TACK = 1'b0; BRIDGE_ACK = 1'b0; LIDE_ACK = 1'b0; PRO_ACK = 1'b0;
      tick(); tick();
      RESETn = 1'b1;
      chk("reset_outs", 16'(outs()), 16'(6'b000011));

      // 1: autoconfig claim, ack two clocks after the claim edge
      A = 16'h00E8; #1;
      chk("ac_space", 16'(AUTOCONFIG_SPACE), 16'd1);
      TSn = 1'b0; tick(); TSn = 1'b1;
      chk("ac_no_sel", 16'(outs()), 16'(6'b000011));
      tick();
      AC_TACK = 1'b1; tick(); AC_TACK = 1'b0;
      chk("ac_ta", 16'(outs()), 16'(6'b000101));
      tick();
      chk("ac_recover", 16'(outs()), 16'(6'b000111));
      tick();
      chk("ac_idle", 16'(outs()), 16'(6'b000011));
      AC_TACK = 1'b1; tick(); AC_TACK = 1'b0; tick();
      chk("ack_idle_ignored", 16'(outs()), 16'(6'b000011));

      // 2: bridge claim, ack after 4 clocks
      BRIDGE_BASE = 8'hE9; LIDE_BASE = 7'h01; PRO_BASE = 4'h4;
      CONFIGURED = 1'b1; A = 16'h00E9; #1;
      chk("brg_ac_space_off", 16'(AUTOCONFIG_SPACE), 16'd0);
      TSn = 1'b0; tick(); TSn = 1'b1;
      A = 16'h4123;  // later address changes must not matter
      chk("brg_sel", 16'(outs()), 16'(6'b100011));
      tick(); tick(); tick();
      chk("brg_hold", 16'(outs()), 16'(6'b100011));
      BRIDGE_ACK = 1'b1; tick(); BRIDGE_ACK = 1'b0;
      chk("brg_ta_sel_drop", 16'(outs()), 16'(6'b000101));
      tick(); tick();
      chk("brg_idle", 16'(outs()), 16'(6'b000011));

      // 3: Prometheus claim, no ack -> TEAn exactly TIMEOUT clocks after claim
      A = 16'h4123;
      TSn = 1'b0; tick(); TSn = 1'b1;
      chk("pro_sel", 16'(outs()), 16'(6'b001011));
      early_tea = 1'b0;
      for (int i = 1; i < int'(TIMEOUT); i++) begin
         tick();
         if (!TEAn || TERM_OE) early_tea = 1'b1;
      end
      chk("pro_no_early_tea", 16'(early_tea), 16'd0);
      chk("pro_sel_before_to", 16'(outs()), 16'(6'b001011));
      tick();
      chk("pro_tea", 16'(outs()), 16'(6'b000110));
      tick();
      chk("pro_recover", 16'(outs()), 16'(6'b000111));
      tick();

      // 4: LIDE claim; foreign ack ignored; own ack on timeout edge wins
      LIDE_BASE = 7'h75; A = 16'h00EB;
      TSn = 1'b0; tick(); TSn = 1'b1;
      chk("lide_sel", 16'(outs()), 16'(6'b010011));
      PRO_ACK = 1'b1; tick(); PRO_ACK = 1'b0;
      chk("lide_foreign_ack", 16'(outs()), 16'(6'b010011));
      for (int i = 2; i < int'(TIMEOUT); i++) tick();
      LIDE_ACK = 1'b1; tick(); LIDE_ACK = 1'b0;
      chk("lide_ack_beats_to", 16'(outs()), 16'(6'b000101));
      tick(); tick();

      // 5: no-hit address, then TSn during an active cycle
      A = 16'h0010;
      TSn = 1'b0; tick(); TSn = 1'b1;
      chk("nohit_first", 16'(outs()), 16'(6'b000011));
      BRIDGE_ACK = 1'b1; tick(); BRIDGE_ACK = 1'b0;
      chk("nohit_ack", 16'(outs()), 16'(6'b000011));
      A = 16'h00E9;
      TSn = 1'b0; tick(); TSn = 1'b1;
      A = 16'h4123;
      TSn = 1'b0; tick(); TSn = 1'b1;
      chk("nested_ts_ignored", 16'(outs()), 16'(6'b100011));
      BRIDGE_ACK = 1'b1; tick(); BRIDGE_ACK = 1'b0;
      chk("nested_brg_ta", 16'(outs()), 16'(6'b000101));
      tick(); tick(); tick();
      chk("nested_idle", 16'(outs()), 16'(6'b000011));

      // 6: reset while active aborts silently
      A = 16'h00E9;
      TSn = 1'b0; tick(); TSn = 1'b1;
      chk("abort_sel", 16'(outs()), 16'(6'b100011));
      tick();
      RESETn = 1'b0; tick(); RESETn = 1'b1;
      chk("abort_reset", 16'(outs()), 16'(6'b000011));
      any_term = 1'b0;
      BRIDGE_ACK = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (TERM_OE || !TAn || !TEAn) any_term = 1'b1;
         BRIDGE_ACK = 1'b0;
      end
      chk("abort_no_term", 16'(any_term), 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
